// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: widths, opcodes, flag indices,
// condition codes and FSM state encoding.
package alu_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned COND_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [OP_W-1:0] OP_AND = 4'h2;
  localparam logic [OP_W-1:0] OP_OR  = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR = 4'h4;
  localparam logic [OP_W-1:0] OP_SLL = 4'h8;
  localparam logic [OP_W-1:0] OP_SLR = 4'h9;
  localparam logic [OP_W-1:0] OP_SRL = 4'hA;
  localparam logic [OP_W-1:0] OP_SRA = 4'hB;
  localparam logic [OP_W-1:0] OP_NON = 4'hF;

  // Flag vector order is {S,Z,C,V}
  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [COND_W-1:0] COND_ALWAYS = 3'd0;
  localparam logic [COND_W-1:0] COND_EQ     = 3'd1;
  localparam logic [COND_W-1:0] COND_NE     = 3'd2;
  localparam logic [COND_W-1:0] COND_LT     = 3'd3;
  localparam logic [COND_W-1:0] COND_GE     = 3'd4;
  localparam logic [COND_W-1:0] COND_LE     = 3'd5;
  localparam logic [COND_W-1:0] COND_GT     = 3'd6;
  localparam logic [COND_W-1:0] COND_CS     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return !(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_SLL, OP_SLR, OP_SRL, OP_SRA, OP_NON});
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command/response bundle between the decode stage (master) and the ALU controller (slave).
interface alu_seq_ctrl_if;
  import alu_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OP_W-1:0]      cmd_op;
  logic [WIDTH-1:0]     cmd_a;
  logic [WIDTH-1:0]     cmd_b;
  logic [COND_W-1:0]    cmd_cond;

  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     res_data;
  logic [FLAG_W-1:0]    res_flags;
  logic                 res_cond;
  logic                 res_illegal;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cond, res_ready,
    input  cmd_ready, res_valid, res_data, res_flags, res_cond, res_illegal
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cond, res_ready,
    output cmd_ready, res_valid, res_data, res_flags, res_cond, res_illegal
  );

endinterface

// File: rtl/alu_cond_eval.sv
// Combinational condition evaluator: maps a {S,Z,C,V} flag vector and a condition code to a verdict.
module alu_cond_eval
  import alu_pkg::*;
(
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [COND_W-1:0] cond_i,
  output logic              verdict_o
);

  logic lt_c;

  always_comb begin
    verdict_o = 1'b0;
    lt_c      = flags_i[FLAG_S] ^ flags_i[FLAG_V];
    case (cond_i)
      COND_ALWAYS: verdict_o = 1'b1;
      COND_EQ:     verdict_o = flags_i[FLAG_Z];
      COND_NE:     verdict_o = !flags_i[FLAG_Z];
      COND_LT:     verdict_o = lt_c;
      COND_GE:     verdict_o = !lt_c;
      COND_LE:     verdict_o = flags_i[FLAG_Z] | lt_c;
      COND_GT:     verdict_o = !flags_i[FLAG_Z] & !lt_c;
      COND_CS:     verdict_o = flags_i[FLAG_C];
      default:     verdict_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Initiator for the 16-bit combinational ALU: one command in, one registered response out.
// Optional condition evaluation is built when ALU_SEQ_COND_EN is defined.
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  alu_seq_ctrl_if.slave     bus,
  output logic [WIDTH-1:0]  alu_a_o,
  output logic [WIDTH-1:0]  alu_b_o,
  output logic [OP_W-1:0]   alu_s_o,
  input  logic [WIDTH-1:0]  alu_y_i,
  input  logic [FLAG_W-1:0] alu_f_i
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    res_data_q, res_data_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                res_cond_q, res_cond_d;
  logic                res_ill_q, res_ill_d;
  logic [FLAG_W-1:0]   new_flags_c;
  logic                cond_c;

  // NON leaves the flag register untouched, so conditions see the old flags
  assign new_flags_c = (op_q == OP_NON) ? flags_q : alu_f_i;

`ifdef ALU_SEQ_COND_EN
  logic [COND_W-1:0]   cond_q, cond_d;

  alu_cond_eval u_cond_eval (
    .flags_i   (new_flags_c),
    .cond_i    (cond_q),
    .verdict_o (cond_c)
  );
`else
  logic unused_cond;
  assign unused_cond = ^bus.cmd_cond;
  assign cond_c      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    flags_d    = flags_q;
    res_cond_d = res_cond_q;
    res_ill_d  = res_ill_q;
`ifdef ALU_SEQ_COND_EN
    cond_d     = cond_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
`ifdef ALU_SEQ_COND_EN
          cond_d  = bus.cmd_cond;
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        res_data_d = (op_q == OP_NON) ? WIDTH'(0) : alu_y_i;
        flags_d    = new_flags_c;
        res_cond_d = cond_c;
        res_ill_d  = op_is_illegal(op_q);
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NON;
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      flags_q    <= '0;
      res_cond_q <= 1'b0;
      res_ill_q  <= 1'b0;
`ifdef ALU_SEQ_COND_EN
      cond_q     <= COND_ALWAYS;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      flags_q    <= flags_d;
      res_cond_q <= res_cond_d;
      res_ill_q  <= res_ill_d;
`ifdef ALU_SEQ_COND_EN
      cond_q     <= cond_d;
`endif
    end
  end

  // Select is only live while issuing; operands simply hold
  assign alu_s_o         = (state_q == ST_ISSUE) ? op_q : OP_NON;
  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;

  assign bus.cmd_ready   = (state_q == ST_IDLE) & rst_ni;
  assign bus.res_valid   = (state_q == ST_RESP);
  assign bus.res_data    = res_data_q;
  assign bus.res_flags   = flags_q;
  assign bus.res_cond    = res_cond_q;
  assign bus.res_illegal = res_ill_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural 16-bit ALU attached.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_y;
  logic [OP_W-1:0]   alu_s;
  logic [FLAG_W-1:0] alu_f;

  int checks   = 0;
  int failures = 0;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus.slave),
    .alu_a_o (alu_a),
    .alu_b_o (alu_b),
    .alu_s_o (alu_s),
    .alu_y_i (alu_y),
    .alu_f_i (alu_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; NON returns junk so the controller must ignore it
  logic [16:0] m_sum;
  logic [31:0] m_rot;
  logic        m_c, m_v;
  always_comb begin
    m_sum = '0;
    m_rot = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    alu_y = '0;
    case (alu_s)
      4'h0: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y = m_sum[15:0];
        m_c   = m_sum[16];
        m_v   = (alu_a[15] == alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      4'h1: begin
        alu_y = alu_a - alu_b;
        m_c   = alu_a < alu_b;
        m_v   = (alu_a[15] != alu_b[15]) && (alu_y[15] != alu_a[15]);
      end
      4'h2: alu_y = alu_a & alu_b;
      4'h3: alu_y = alu_a | alu_b;
      4'h4: alu_y = alu_a ^ alu_b;
      4'h8: alu_y = alu_a << alu_b[3:0];
      4'h9: begin
        m_rot = {alu_a, alu_a} << alu_b[3:0];
        alu_y = m_rot[31:16];
      end
      4'hA: alu_y = alu_a >> alu_b[3:0];
      4'hB: alu_y = 16'($signed(alu_a) >>> alu_b[3:0]);
      4'hF: alu_y = 16'h1234;
      default: alu_y = '0;
    endcase
    alu_f = {alu_y[15], (alu_y == 16'h0), m_c, m_v};
    if (alu_s == 4'hF) alu_f = 4'b0011;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_exp(input logic v);
`ifdef ALU_SEQ_COND_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Runs one command from IDLE through the response handshake; phase is posedge+1
  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] cond, input logic [15:0] e_data,
                         input logic [3:0] e_flags, input logic e_cond_en,
                         input logic e_ill, input int stall);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_cond  = cond;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("issue_res_valid", 32'(bus.res_valid), 32'd0);
    chk("issue_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("issue_alu_s", 32'(alu_s), 32'(op));
    chk("issue_alu_a", 32'(alu_a), 32'(a));
    chk("issue_alu_b", 32'(alu_b), 32'(b));
    @(posedge clk); #1;
    chk("resp_valid", 32'(bus.res_valid), 32'd1);
    chk("resp_data", 32'(bus.res_data), 32'(e_data));
    chk("resp_flags", 32'(bus.res_flags), 32'(e_flags));
    chk("resp_cond", 32'(bus.res_cond), 32'(cond_exp(e_cond_en)));
    chk("resp_illegal", 32'(bus.res_illegal), 32'(e_ill));
    chk("resp_alu_s", 32'(alu_s), 32'(OP_NON));
    if (stall > 0) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_XOR;
      bus.cmd_a     = 16'hFFFF;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(bus.res_valid), 32'd1);
      chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("stall_data", 32'(bus.res_data), 32'(e_data));
      chk("stall_flags", 32'(bus.res_flags), 32'(e_flags));
      chk("stall_alu_s", 32'(alu_s), 32'(OP_NON));
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("done_res_valid", 32'(bus.res_valid), 32'd0);
    chk("done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("done_flags_kept", 32'(bus.res_flags), 32'(e_flags));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_cond  = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_flags", 32'(bus.res_flags), 32'd0);
    chk("rst_res_cond", 32'(bus.res_cond), 32'd0);
    chk("rst_res_illegal", 32'(bus.res_illegal), 32'd0);
    chk("rst_alu_s", 32'(alu_s), 32'hF);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow into sign bit; NE on Z=0
    run_cmd(OP_ADD, 16'h7FFF, 16'h0001, COND_NE, 16'h8000, 4'b1001, 1'b1, 1'b0, 0);
    // SUB equal operands; EQ
    run_cmd(OP_SUB, 16'h0005, 16'h0005, COND_EQ, 16'h0000, 4'b0100, 1'b1, 1'b0, 0);
    // NON keeps flags, zero data; GE on kept flags
    run_cmd(OP_NON, 16'hAAAA, 16'h5555, COND_GE, 16'h0000, 4'b0100, 1'b1, 1'b0, 0);
    // AND with 5-cycle backpressure and a stray command held meanwhile; LE false
    run_cmd(OP_AND, 16'hF0F0, 16'h0FF0, COND_LE, 16'h00F0, 4'b0000, 1'b0, 1'b0, 5);
    // XOR negative result; LT true (S^V=1)
    run_cmd(OP_XOR, 16'hFFFF, 16'h0001, COND_LT, 16'hFFFE, 4'b1000, 1'b1, 1'b0, 0);
    // SRA keeps sign; GT false
    run_cmd(OP_SRA, 16'h8000, 16'h0004, COND_GT, 16'hF800, 4'b1000, 1'b0, 1'b0, 0);
    // Undefined opcode; CS on C=0
    run_cmd(4'h5, 16'h1234, 16'h5678, COND_CS, 16'h0000, 4'b0100, 1'b0, 1'b1, 0);

    // Reset during ISSUE abandons the command
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 16'h0001;
    bus.cmd_b     = 16'h0001;
    bus.cmd_cond  = COND_ALWAYS;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("mid_issue_alu_s", 32'(alu_s), 32'(OP_ADD));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_flags", 32'(bus.res_flags), 32'd0);
    chk("mid_rst_illegal", 32'(bus.res_illegal), 32'd0);
    chk("mid_rst_alu_s", 32'(alu_s), 32'hF);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_resp", 32'(bus.res_valid), 32'd0);
      chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    end

    // Normal operation resumes after reset
    run_cmd(OP_ADD, 16'h0002, 16'h0003, COND_ALWAYS, 16'h0005, 4'b0000, 1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
